alu_writeback: RTL and testbench
================================

Name: alu_writeback

Overview:
- Stage directly downstream of the ALU.
- Captures each ALU result and its Z/C/N flags into a 2-entry buffer, then drains entries into the register-file write port under a ready handshake.
- Holds the architectural flag register and evaluates branch conditions from it for the control unit.
- Decouples ALU issue from register-file port stalls.

Parameters:
- DATA_BUS_WIDTH, 16, width of result and register-file data.
- REG_ADDR_BITS, 3, register-file address width.
- COND_NUM_BITS, 3, width of condition-code select.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- In_Valid  in  1  ALU output is a valid instruction result this cycle.
- In_Ready  out  1  stage can accept an entry this cycle.
- Result  in  DATA_BUS_WIDTH  ALU result.
- Z  in  1  ALU zero flag.
- C  in  1  ALU carry flag.
- N  in  1  ALU negative flag.
- Dest_Reg  in  REG_ADDR_BITS  destination register.
- Write_Reg  in  1  the entry writes the register file.
- Write_Flags  in  1  the entry updates the flag register.
- Rf_Wr_En  out  1  register-file write request.
- Rf_Wr_Addr  out  REG_ADDR_BITS  write address (head entry).
- Rf_Wr_Data  out  DATA_BUS_WIDTH  write data (head entry).
- Rf_Ready  in  1  register-file port accepts the write this cycle.
- Flag_Z  out  1  architectural Z.
- Flag_C  out  1  architectural C.
- Flag_N  out  1  architectural N.
- Cond_Sel  in  COND_NUM_BITS  condition to evaluate.
- Cond_True  out  1  selected condition holds.

Behaviour:
- Reset (async, immediate):
  - entry count = 0, read/write pointers = 0.
  - Flag_Z = Flag_C = Flag_N = 0.
  - Rf_Wr_En = 0, In_Ready = 1.
  - Rf_Wr_Addr and Rf_Wr_Data = 0 while the buffer is empty.
  - Any buffered entries are discarded; no partial write is issued after Reset deasserts.
- Buffer: 2-entry FIFO of {Result, Dest_Reg, Write_Reg}.
  - In_Ready = (count < 2), derived from registered count only; no combinational path from Rf_Ready.
- Accept = In_Valid & In_Ready. On accept the entry is written at the tail; count increments unless a pop occurs in the same cycle.
- Head presentation:
  - When count > 0: Rf_Wr_En = head.Write_Reg, Rf_Wr_Addr = head.Dest_Reg, Rf_Wr_Data = head.Result.
  - When count = 0: Rf_Wr_En = 0.
- Pop = (count > 0) & (Rf_Ready | ~head.Write_Reg). A flags-only entry (Write_Reg = 0) pops in one cycle without a write request.
- Latency: an entry accepted at edge k is presented at the head from cycle k+1. There is no same-cycle bypass from input to Rf_Wr_*.
- Simultaneous events:
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - count = 2: In_Ready = 0, so no push is possible; the ALU must hold its inputs.
- Pointers: 1 bit each, wrap 1 -> 0.
- Flags:
  - On accept with Write_Flags = 1, {Flag_Z, Flag_C, Flag_N} <= {Z, C, N} at that edge. Flags therefore reflect issue order and do not wait for the register-file drain.
  - Write_Flags = 0: flags hold.
  - Input is ignored when In_Ready = 0.
- Cond_True is combinational from the flag register and Cond_Sel:
  - 0 ALWAYS: 1
  - 1 EQ: Z
  - 2 NE: ~Z
  - 3 CS: C
  - 4 CC: ~C
  - 5 MI: N
  - 6 PL: ~N
  - 7 NEVER: 0
- Held Rf_Wr_* values remain stable while Rf_Ready = 0; they change only on a pop.

Decomposition:
- params.v gains:
  - REG_ADDR_BITS.
  - COND_NUM_BITS.
  - COND_ALWAYS, COND_EQ, COND_NE, COND_CS, COND_CC, COND_MI, COND_PL, COND_NEVER.
- One sub-module, wb_fifo2: a 2-entry FIFO with count, push/pop and head outputs, parameterised on entry width.
- alu_writeback instantiates wb_fifo2 and contains the pop logic, flag register and condition mux.

Test Plan:
- Reset then single entry: Result=0x1234, Dest=3, Write_Reg=1, Rf_Ready=1 -> next cycle Rf_Wr_En=1, Addr=3, Data=0x1234; the cycle after, Rf_Wr_En=0 and In_Ready=1.
- Backpressure: Rf_Ready=0, push 0x0001 then 0x0002 -> In_Ready=0 after the second push; a third valid is not accepted. Rf_Ready=1 -> writes occur in order 0x0001, 0x0002 on consecutive cycles.
- Flags: accept Z=1,C=1,N=0 with Write_Flags=1, then an entry with Write_Flags=0 and Z=0 -> Flag_Z stays 1. Cond_Sel=1 -> Cond_True=1; Cond_Sel=4 -> 0; Cond_Sel=7 -> 0.
- Flags-only entry: Write_Reg=0, Rf_Ready=0 -> Rf_Wr_En never asserts, the entry pops in 1 cycle and count returns to 0.
- Simultaneous push/pop at count=1 with Rf_Ready=1 for 4 cycles of streaming input -> one write per cycle, count stays 1, no entries dropped or duplicated.
- Reset asserted mid-operation with count=2, Rf_Ready=0 -> Rf_Wr_En=0 and flags=0 immediately; after deassert In_Ready=1 and no stale write appears.

Source files
------------

// File: rtl/alu_writeback_pkg.sv
// rtl/alu_writeback_pkg.sv - shared widths and condition-code encodings for the ALU writeback stage
package alu_writeback_pkg;

    localparam int DEFAULT_DATA_BUS_WIDTH = 16;
    localparam int REG_ADDR_BITS          = 3;
    localparam int COND_NUM_BITS          = 3;

    localparam logic [2:0] COND_ALWAYS = 3'd0;
    localparam logic [2:0] COND_EQ     = 3'd1;
    localparam logic [2:0] COND_NE     = 3'd2;
    localparam logic [2:0] COND_CS     = 3'd3;
    localparam logic [2:0] COND_CC     = 3'd4;
    localparam logic [2:0] COND_MI     = 3'd5;
    localparam logic [2:0] COND_PL     = 3'd6;
    localparam logic [2:0] COND_NEVER  = 3'd7;

endpackage

// File: rtl/alu_writeback_wb_fifo2.sv
// rtl/alu_writeback_wb_fifo2.sv - two-entry FIFO with occupancy count and zeroed head when empty
module wb_fifo2 #(
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [1:0]       count,
    output logic [WIDTH-1:0] head_data
);

    logic [WIDTH-1:0] mem_q [2];
    logic [WIDTH-1:0] mem_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        count_d  = count_q + {1'b0, push} - {1'b0, pop};
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Empty buffer presents zeros so stale entries never reach the write port.
    assign count     = count_q;
    assign head_data = (count_q != 2'd0) ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/alu_writeback.sv
// rtl/alu_writeback.sv - buffers ALU results toward the register file and holds architectural flags
module alu_writeback
    import alu_writeback_pkg::*;
#(
    parameter int DATA_BUS_WIDTH = DEFAULT_DATA_BUS_WIDTH
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      In_Valid,
    output logic                      In_Ready,
    input  logic [DATA_BUS_WIDTH-1:0] Result,
    input  logic                      Z,
    input  logic                      C,
    input  logic                      N,
    input  logic [REG_ADDR_BITS-1:0]  Dest_Reg,
    input  logic                      Write_Reg,
    input  logic                      Write_Flags,
    output logic                      Rf_Wr_En,
    output logic [REG_ADDR_BITS-1:0]  Rf_Wr_Addr,
    output logic [DATA_BUS_WIDTH-1:0] Rf_Wr_Data,
    input  logic                      Rf_Ready,
    output logic                      Flag_Z,
    output logic                      Flag_C,
    output logic                      Flag_N,
    input  logic [COND_NUM_BITS-1:0]  Cond_Sel,
    output logic                      Cond_True
);

    localparam int ENTRY_W = DATA_BUS_WIDTH + REG_ADDR_BITS + 1;

    logic [ENTRY_W-1:0] head;
    logic [1:0]         count;
    logic               accept;
    logic               pop;
    logic               head_valid;
    logic               head_wr;
    logic [2:0]         flags_q, flags_d;

    wb_fifo2 #(.WIDTH(ENTRY_W)) u_fifo (
        .clk       (Clk),
        .rst       (Reset),
        .push      (accept),
        .pop       (pop),
        .push_data ({Result, Dest_Reg, Write_Reg}),
        .count     (count),
        .head_data (head)
    );

    // Ready depends only on registered occupancy, never on Rf_Ready.
    assign In_Ready   = (count != 2'd2);
    assign accept     = In_Valid & In_Ready;
    assign head_valid = (count != 2'd0);
    assign head_wr    = head[0];
    assign pop        = head_valid & (Rf_Ready | ~head_wr);

    assign Rf_Wr_En   = head_valid & head_wr;
    assign Rf_Wr_Addr = head[REG_ADDR_BITS:1];
    assign Rf_Wr_Data = head[ENTRY_W-1 -: DATA_BUS_WIDTH];

    always_comb begin
        flags_d = flags_q;
        if (accept && Write_Flags) begin
            flags_d = {Z, C, N};
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            flags_q <= 3'b000;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign Flag_Z = flags_q[2];
    assign Flag_C = flags_q[1];
    assign Flag_N = flags_q[0];

    always_comb begin
        Cond_True = 1'b0;
        case (Cond_Sel)
            COND_ALWAYS: Cond_True = 1'b1;
            COND_EQ:     Cond_True = Flag_Z;
            COND_NE:     Cond_True = ~Flag_Z;
            COND_CS:     Cond_True = Flag_C;
            COND_CC:     Cond_True = ~Flag_C;
            COND_MI:     Cond_True = Flag_N;
            COND_PL:     Cond_True = ~Flag_N;
            COND_NEVER:  Cond_True = 1'b0;
            default:     Cond_True = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_alu_writeback.sv
// tb/tb_alu_writeback.sv - vector table plus scoreboard bench for alu_writeback
module tb_alu_writeback;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        In_Valid;
    logic        In_Ready;
    logic [15:0] Result;
    logic        Z, C, N;
    logic [2:0]  Dest_Reg;
    logic        Write_Reg;
    logic        Write_Flags;
    logic        Rf_Wr_En;
    logic [2:0]  Rf_Wr_Addr;
    logic [15:0] Rf_Wr_Data;
    logic        Rf_Ready;
    logic        Flag_Z, Flag_C, Flag_N;
    logic [2:0]  Cond_Sel;
    logic        Cond_True;

    alu_writeback dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .In_Valid    (In_Valid),
        .In_Ready    (In_Ready),
        .Result      (Result),
        .Z           (Z),
        .C           (C),
        .N           (N),
        .Dest_Reg    (Dest_Reg),
        .Write_Reg   (Write_Reg),
        .Write_Flags (Write_Flags),
        .Rf_Wr_En    (Rf_Wr_En),
        .Rf_Wr_Addr  (Rf_Wr_Addr),
        .Rf_Wr_Data  (Rf_Wr_Data),
        .Rf_Ready    (Rf_Ready),
        .Flag_Z      (Flag_Z),
        .Flag_C      (Flag_C),
        .Flag_N      (Flag_N),
        .Cond_Sel    (Cond_Sel),
        .Cond_True   (Cond_True)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        v;
        logic [15:0] res;
        logic        z, c, n;
        logic [2:0]  dest;
        logic        wr, wf, rdy;
        logic [2:0]  sel;
        logic        ir, en, ct;
    } vec_t;

    typedef struct {
        logic [15:0] data;
        logic [2:0]  addr;
        logic        wr;
    } entry_t;

    entry_t     sb[$];
    logic [2:0] flags_m;
    int         total = 0;
    int         bad   = 0;
    vec_t       vecs[25];
    vec_t       rvec[2];

    function automatic vec_t mk(logic v, logic [15:0] res, logic z, logic c, logic n,
                                logic [2:0] dest, logic wr, logic wf, logic rdy,
                                logic [2:0] sel, logic ir, logic en, logic ct);
        vec_t t;
        t.v = v; t.res = res; t.z = z; t.c = c; t.n = n; t.dest = dest;
        t.wr = wr; t.wf = wf; t.rdy = rdy; t.sel = sel;
        t.ir = ir; t.en = en; t.ct = ct;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input vec_t t, input int idx);
        entry_t e;
        logic [15:0] exp_data;
        logic [2:0]  exp_addr;
        In_Valid    = t.v;
        Result      = t.res;
        Z           = t.z;
        C           = t.c;
        N           = t.n;
        Dest_Reg    = t.dest;
        Write_Reg   = t.wr;
        Write_Flags = t.wf;
        Rf_Ready    = t.rdy;
        Cond_Sel    = t.sel;
        @(negedge Clk);
        exp_data = (sb.size() > 0) ? sb[0].data : 16'h0;
        exp_addr = (sb.size() > 0) ? sb[0].addr : 3'h0;
        check($sformatf("in_ready[%0d]", idx), 32'(In_Ready), 32'(t.ir));
        check($sformatf("wr_en[%0d]", idx), 32'(Rf_Wr_En), 32'(t.en));
        check($sformatf("cond[%0d]", idx), 32'(Cond_True), 32'(t.ct));
        check($sformatf("wr_data[%0d]", idx), 32'(Rf_Wr_Data), 32'(exp_data));
        check($sformatf("wr_addr[%0d]", idx), 32'(Rf_Wr_Addr), 32'(exp_addr));
        check($sformatf("flags[%0d]", idx), 32'({Flag_Z, Flag_C, Flag_N}), 32'(flags_m));
        if (sb.size() > 0 && (t.rdy || !sb[0].wr)) begin
            void'(sb.pop_front());
        end
        if (t.v && In_Ready) begin
            e.data = t.res;
            e.addr = t.dest;
            e.wr   = t.wr;
            if (sb.size() < 2) sb.push_back(e);
            if (t.wf) flags_m = {t.z, t.c, t.n};
        end
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset = 1'b1;
        In_Valid = 0; Result = 0; Z = 0; C = 0; N = 0; Dest_Reg = 0;
        Write_Reg = 0; Write_Flags = 0; Rf_Ready = 0; Cond_Sel = 0;
        flags_m = 3'b000;

        //            v  res      z  c  n  d  wr wf rdy sel ir en ct
        vecs[0]  = mk(1, 16'h1234, 0, 0, 0, 3, 1, 0, 1, 0, 1, 0, 1);
        vecs[1]  = mk(0, 16'h0000, 0, 0, 0, 0, 0, 0, 1, 7, 1, 1, 0);
        vecs[2]  = mk(0, 16'h0000, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0);
        vecs[3]  = mk(1, 16'h0001, 0, 0, 0, 1, 1, 0, 0, 2, 1, 0, 1);
        vecs[4]  = mk(1, 16'h0002, 0, 0, 0, 2, 1, 0, 0, 0, 1, 1, 1);
        vecs[5]  = mk(1, 16'h0003, 0, 0, 0, 4, 1, 0, 0, 0, 0, 1, 1);
        vecs[6]  = mk(0, 16'h0000, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1);
        vecs[7]  = mk(0, 16'h0000, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 1);
        vecs[8]  = mk(0, 16'h0000, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1);
        vecs[9]  = mk(1, 16'h0000, 1, 1, 0, 5, 1, 1, 1, 1, 1, 0, 0);
        vecs[10] = mk(1, 16'h00FF, 0, 0, 1, 6, 1, 0, 1, 1, 1, 1, 1);
        vecs[11] = mk(0, 16'h0000, 0, 0, 0, 0, 0, 0, 1, 4, 1, 1, 0);
        vecs[12] = mk(0, 16'h0000, 0, 0, 0, 0, 0, 0, 1, 7, 1, 0, 0);
        vecs[13] = mk(0, 16'h0000, 0, 0, 0, 0, 0, 0, 1, 3, 1, 0, 1);
        vecs[14] = mk(0, 16'h0000, 0, 0, 0, 0, 0, 0, 1, 5, 1, 0, 0);
        vecs[15] = mk(0, 16'h0000, 0, 0, 0, 0, 0, 0, 1, 6, 1, 0, 1);
        vecs[16] = mk(1, 16'hBEEF, 0, 1, 1, 7, 0, 1, 0, 0, 1, 0, 1);
        vecs[17] = mk(0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        vecs[18] = mk(0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 5, 1, 0, 1);
        vecs[19] = mk(1, 16'h1001, 0, 0, 0, 1, 1, 0, 1, 0, 1, 0, 1);
        vecs[20] = mk(1, 16'h1002, 0, 0, 0, 2, 1, 0, 1, 0, 1, 1, 1);
        vecs[21] = mk(1, 16'h1003, 0, 0, 0, 3, 1, 0, 1, 0, 1, 1, 1);
        vecs[22] = mk(1, 16'h1004, 0, 0, 0, 4, 1, 0, 1, 0, 1, 1, 1);
        vecs[23] = mk(0, 16'h0000, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 1);
        vecs[24] = mk(0, 16'h0000, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1);

        rvec[0]  = mk(1, 16'hAAAA, 1, 1, 1, 1, 1, 1, 0, 0, 1, 0, 1);
        rvec[1]  = mk(1, 16'h5555, 0, 0, 0, 2, 1, 0, 0, 1, 1, 1, 1);

        repeat (3) @(posedge Clk);
        #1;
        Reset = 1'b0;
        @(negedge Clk);
        check("rst_in_ready", 32'(In_Ready), 32'd1);
        check("rst_wr_en", 32'(Rf_Wr_En), 32'd0);
        check("rst_wr_addr", 32'(Rf_Wr_Addr), 32'd0);
        check("rst_wr_data", 32'(Rf_Wr_Data), 32'd0);
        check("rst_flags", 32'({Flag_Z, Flag_C, Flag_N}), 32'd0);
        @(posedge Clk);
        #1;

        for (int i = 0; i < 25; i++) begin
            step(vecs[i], i);
        end
        check("drained", 32'(sb.size()), 32'd0);

        step(rvec[0], 100);
        step(rvec[1], 101);
        In_Valid = 1'b0;
        Reset = 1'b1;
        #2;
        check("midrst_wr_en", 32'(Rf_Wr_En), 32'd0);
        check("midrst_flags", 32'({Flag_Z, Flag_C, Flag_N}), 32'd0);
        check("midrst_in_ready", 32'(In_Ready), 32'd1);
        check("midrst_wr_data", 32'(Rf_Wr_Data), 32'd0);
        sb.delete();
        flags_m = 3'b000;
        @(negedge Clk);
        #2;
        Reset = 1'b0;
        @(posedge Clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            step(mk(0, 16'h0000, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0), 200 + i);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
